wb_arbiter2: RTL and testbench

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arbiter2_if.sv | 64 ++++++
 rtl/wb_arbiter2.sv | 182 ++++++++++++++++++
 tb/tb_wb_arbiter2.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter2_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter2_if
// Bus bundle between two pipelined Wishbone masters, the wb_arbiter2 block and
// a single shared slave.
//
// Signal groups (names are from the arbiter's point of view):
//   i_m_cyc/stb/we [1:0]  per-master cycle, strobe, write enable (bit n = master n)
//   i_m_addr  [59:0]      per-master word address, [30n+29:30n] = master n
//   i_m_data  [63:0]      per-master write data,   [32n+31:32n] = master n
//   i_m_sel   [7:0]       per-master byte selects, [4n+3:4n]   = master n
//   o_m_ack/stall/err     per-master responses
//   o_m_data  [31:0]      read data, shared by both masters
//   o_s_*                 request to the slave
//   i_s_*                 response from the slave
//
// Modports:
//   slave  : the arbiter's view (takes master requests and slave responses)
//   master : the environment's view (drives requests/responses, sees outputs)
// -----------------------------------------------------------------------------
interface wb_arbiter2_if;

  // Master-side requests
  logic [1:0]  i_m_cyc;
  logic [1:0]  i_m_stb;
  logic [1:0]  i_m_we;
  logic [59:0] i_m_addr;
  logic [63:0] i_m_data;
  logic [7:0]  i_m_sel;

  // Master-side responses
  logic [1:0]  o_m_ack;
  logic [1:0]  o_m_stall;
  logic [1:0]  o_m_err;
  logic [31:0] o_m_data;

  // Slave-side request
  logic        o_s_cyc;
  logic        o_s_stb;
  logic        o_s_we;
  logic [29:0] o_s_addr;
  logic [31:0] o_s_data;
  logic [3:0]  o_s_sel;

  // Slave-side response
  logic        i_s_ack;
  logic        i_s_stall;
  logic        i_s_err;
  logic [31:0] i_s_data;

  modport slave (
    input  i_m_cyc, i_m_stb, i_m_we, i_m_addr, i_m_data, i_m_sel,
    output o_m_ack, o_m_stall, o_m_err, o_m_data,
    output o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel,
    input  i_s_ack, i_s_stall, i_s_err, i_s_data
  );

  modport master (
    output i_m_cyc, i_m_stb, i_m_we, i_m_addr, i_m_data, i_m_sel,
    input  o_m_ack, o_m_stall, o_m_err, o_m_data,
    input  o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel,
    output i_s_ack, i_s_stall, i_s_err, i_s_data
  );

endinterface

// File: rtl/wb_arbiter2.sv
// -----------------------------------------------------------------------------
// wb_arbiter2
// Two-master to one-slave pipelined Wishbone arbiter.
//
//  - Grant is registered: a master sampled with cyc high in IDLE owns the bus
//    from the next cycle and keeps it for as long as it holds cyc.
//  - Ties in IDLE go to the master that did not win last time (round-robin).
//  - The request path (cyc/stb/we/addr/data/sel) and the response path
//    (ack/err/stall/data) are muxed combinationally from/to the owner.
//  - An outstanding-request counter throttles the owner at MAX_OUT.
//  - A watchdog errors the owner and drops the slave cycle if no ack/err
//    arrives for TIMEOUT cycles while requests are outstanding.
//
// Parameters:
//   MAX_OUT  maximum outstanding slave requests (1..15)
//   TIMEOUT  idle-response cycles before the watchdog fires (2..4095)
//
// Ports:
//   i_clk     single clock, all state on the rising edge
//   i_resetn  asynchronous active-low reset
//   bus       wb_arbiter2_if.slave bundle (master requests, slave responses)
// -----------------------------------------------------------------------------
module wb_arbiter2 #(
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_resetn,
  wb_arbiter2_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;     // index of the most recent grant winner
  logic [CNT_W-1:0]   cnt_q, cnt_d;       // outstanding slave requests
  logic [TMR_W-1:0]   tmr_q, tmr_d;       // cycles without a response

  logic               own;                // a master currently owns the bus
  logic               own_idx;            // which master owns it
  logic               own_cyc;
  logic               own_stb;
  logic               full;
  logic               timeout;
  logic               released;           // owner dropped cyc this cycle
  logic               accept;             // slave accepted a strobe this cycle
  logic               resp;               // slave responded this cycle
  logic               inc;
  logic               dec;

  // Owner decode and shared status
  always_comb begin
    own      = (state_q == ST_OWN0) || (state_q == ST_OWN1);
    own_idx  = (state_q == ST_OWN1);
    own_cyc  = own && bus.i_m_cyc[own_idx];
    own_stb  = own && bus.i_m_stb[own_idx];
    full     = (cnt_q == CNT_W'(MAX_OUT));
    timeout  = own && (cnt_q != '0) && (tmr_q == TMR_W'(TIMEOUT));
    released = own && !bus.i_m_cyc[own_idx];
  end

  // Slave-side request mux; everything is zero while nobody owns the bus
  always_comb begin
    bus.o_s_cyc  = 1'b0;
    bus.o_s_stb  = 1'b0;
    bus.o_s_we   = 1'b0;
    bus.o_s_addr = '0;
    bus.o_s_data = '0;
    bus.o_s_sel  = '0;
    if (own) begin
      // The watchdog cycle tears the slave cycle down, so no strobe either
      bus.o_s_cyc  = own_cyc && !timeout;
      bus.o_s_stb  = own_stb && !full && !timeout;
      bus.o_s_we   = bus.i_m_we[own_idx];
      bus.o_s_addr = own_idx ? bus.i_m_addr[59:30] : bus.i_m_addr[29:0];
      bus.o_s_data = own_idx ? bus.i_m_data[63:32] : bus.i_m_data[31:0];
      bus.o_s_sel  = own_idx ? bus.i_m_sel[7:4]    : bus.i_m_sel[3:0];
    end
  end

  // Master-side response demux; non-owners are stalled and see no responses
  always_comb begin
    bus.o_m_ack   = 2'b00;
    bus.o_m_err   = 2'b00;
    bus.o_m_stall = 2'b11;
    bus.o_m_data  = bus.i_s_data;
    if (own) begin
      // Ack still reaches an owner that drops cyc in the same cycle.
      // During the watchdog cycle the owner only sees the error, and stays
      // stalled because the slave is not looking at the strobe.
      bus.o_m_ack[own_idx]   = bus.i_s_ack && !timeout;
      bus.o_m_err[own_idx]   = bus.i_s_err || timeout;
      bus.o_m_stall[own_idx] = bus.i_s_stall || full || timeout;
    end
  end

  // Grant FSM: next state and round-robin pointer
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_m_cyc == 2'b11) begin
          if (last_q) begin
            state_d = ST_OWN0;
            last_d  = 1'b0;
          end else begin
            state_d = ST_OWN1;
            last_d  = 1'b1;
          end
        end else if (bus.i_m_cyc[0]) begin
          state_d = ST_OWN0;
          last_d  = 1'b0;
        end else if (bus.i_m_cyc[1]) begin
          state_d = ST_OWN1;
          last_d  = 1'b1;
        end
      end
      ST_OWN0: begin
        if (!bus.i_m_cyc[0]) begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (!bus.i_m_cyc[1]) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outstanding counter and watchdog timer
  always_comb begin
    accept = bus.o_s_stb && !bus.i_s_stall;
    resp   = bus.i_s_ack || bus.i_s_err;
    inc    = accept;
    dec    = resp && (cnt_q != '0);   // stray responses never underflow
    cnt_d  = cnt_q;
    tmr_d  = tmr_q;
    if (!own || released || timeout) begin
      cnt_d = '0;
      tmr_d = '0;
    end else begin
      if (inc && !dec) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (dec && !inc) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      if (resp || (cnt_q == '0)) begin
        tmr_d = '0;
      end else begin
        tmr_d = tmr_q + TMR_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter2
// Directed bench for wb_arbiter2 (MAX_OUT=4, TIMEOUT=8). Each stimulus step
// queues the hand-computed outputs for that cycle; a monitor on the falling
// edge pops and compares them against the DUT.
// -----------------------------------------------------------------------------
module tb_wb_arbiter2;

  typedef struct packed {
    logic [1:0]  ack;
    logic [1:0]  stall;
    logic [1:0]  err;
    logic        scyc;
    logic        sstb;
    logic        chk_bus;
    logic [29:0] saddr;
    logic [31:0] mdata;
  } exp_t;

  localparam logic [29:0] ADDR0 = 30'h1111111;
  localparam logic [29:0] ADDR1 = 30'h2222222;

  logic clk;
  logic resetn;

  wb_arbiter2_if bus ();

  wb_arbiter2 #(
    .MAX_OUT (4),
    .TIMEOUT (8)
  ) dut (
    .i_clk    (clk),
    .i_resetn (resetn),
    .bus      (bus)
  );

  exp_t  exp_q[$];
  string name_q[$];
  int    checks;
  int    errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare everything queued for the current cycle
  exp_t  mon_e;
  string mon_nm;
  logic  mon_bad;
  always @(negedge clk) begin
    while (exp_q.size() != 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      checks = checks + 1;
      mon_bad = (bus.o_m_ack !== mon_e.ack) || (bus.o_m_stall !== mon_e.stall) ||
                (bus.o_m_err !== mon_e.err) || (bus.o_s_cyc !== mon_e.scyc) ||
                (bus.o_s_stb !== mon_e.sstb);
      if (mon_e.chk_bus)
        mon_bad = mon_bad || (bus.o_s_addr !== mon_e.saddr) || (bus.o_m_data !== mon_e.mdata);
      if (mon_bad) begin
        errors = errors + 1;
        $display("FAIL %s: got ack=%b stall=%b err=%b s_cyc=%b s_stb=%b s_addr=%h m_data=%h, expected ack=%b stall=%b err=%b s_cyc=%b s_stb=%b s_addr=%h m_data=%h (bus fields %s)",
                 mon_nm, bus.o_m_ack, bus.o_m_stall, bus.o_m_err, bus.o_s_cyc, bus.o_s_stb,
                 bus.o_s_addr, bus.o_m_data, mon_e.ack, mon_e.stall, mon_e.err, mon_e.scyc,
                 mon_e.sstb, mon_e.saddr, mon_e.mdata, mon_e.chk_bus ? "checked" : "ignored");
      end
    end
  end

  // Queue the expected outputs for this cycle, then advance one clock
  task automatic step(input string nm, input logic [1:0] ack, input logic [1:0] stall,
                      input logic [1:0] err, input logic scyc, input logic sstb);
    exp_t e;
    e       = '0;
    e.ack   = ack;
    e.stall = stall;
    e.err   = err;
    e.scyc  = scyc;
    e.sstb  = sstb;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic step_bus(input string nm, input logic [1:0] ack, input logic [1:0] stall,
                          input logic [1:0] err, input logic scyc, input logic sstb,
                          input logic [29:0] saddr, input logic [31:0] mdata);
    exp_t e;
    e         = '0;
    e.ack     = ack;
    e.stall   = stall;
    e.err     = err;
    e.scyc    = scyc;
    e.sstb    = sstb;
    e.chk_bus = 1'b1;
    e.saddr   = saddr;
    e.mdata   = mdata;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] cyc, input logic [1:0] stb, input logic ack);
    bus.i_m_cyc = cyc;
    bus.i_m_stb = stb;
    bus.i_s_ack = ack;
  endtask

  // Hard stop if the run ever wedges
  initial begin
    #100000;
    $display("FAIL sim_timeout: run did not complete, got no finish, expected finish before 100000");
    $fatal(1, "simulation time limit");
  end

  initial begin
    checks         = 0;
    errors         = 0;
    resetn         = 1'b0;
    bus.i_m_cyc    = 2'b00;
    bus.i_m_stb    = 2'b00;
    bus.i_m_we     = 2'b00;
    bus.i_m_addr   = {ADDR1, ADDR0};
    bus.i_m_data   = {32'hA1A1A1A1, 32'hB0B0B0B0};
    bus.i_m_sel    = 8'hFF;
    bus.i_s_ack    = 1'b0;
    bus.i_s_stall  = 1'b0;
    bus.i_s_err    = 1'b0;
    bus.i_s_data   = 32'h0;
    @(posedge clk);
    #1;

    // Reset state
    step("reset_idle", 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);

    // Round-robin grant sequence
    resetn = 1'b1;
    drv(2'b11, 2'b00, 1'b0);
    step("tie_idle", 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
    step_bus("tie_own0", 2'b00, 2'b10, 2'b00, 1'b1, 1'b0, ADDR0, 32'h0);
    drv(2'b10, 2'b00, 1'b0);
    step("m0_release", 2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
    step("idle_m1_req", 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
    step_bus("own1_grant", 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, ADDR1, 32'h0);
    drv(2'b00, 2'b00, 1'b0);
    step("m1_release", 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
    drv(2'b11, 2'b00, 1'b0);
    step("idle_tie2", 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
    step_bus("rr_own0", 2'b00, 2'b10, 2'b00, 1'b1, 1'b0, ADDR0, 32'h0);

    // Outstanding limit: four accepted, then stalled until an ack
    drv(2'b11, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++)
      step("burst_accept", 2'b00, 2'b10, 2'b00, 1'b1, 1'b1);
    step("burst_full", 2'b00, 2'b11, 2'b00, 1'b1, 1'b0);
    drv(2'b11, 2'b01, 1'b1);
    step("full_ack", 2'b01, 2'b11, 2'b00, 1'b1, 1'b0);
    drv(2'b11, 2'b01, 1'b0);
    step("fifth_accept", 2'b00, 2'b10, 2'b00, 1'b1, 1'b1);
    drv(2'b11, 2'b00, 1'b1);
    step("drain_full", 2'b01, 2'b11, 2'b00, 1'b1, 1'b0);
    step("drain", 2'b01, 2'b10, 2'b00, 1'b1, 1'b0);

    // Accept and ack together at count 2: two more fit before full
    drv(2'b11, 2'b01, 1'b1);
    step("acc_and_ack", 2'b01, 2'b10, 2'b00, 1'b1, 1'b1);
    drv(2'b11, 2'b01, 1'b0);
    step("refill_a", 2'b00, 2'b10, 2'b00, 1'b1, 1'b1);
    step("refill_b", 2'b00, 2'b10, 2'b00, 1'b1, 1'b1);
    step("cnt2_full", 2'b00, 2'b11, 2'b00, 1'b1, 1'b0);
    drv(2'b11, 2'b00, 1'b1);
    step("drain2_full", 2'b01, 2'b11, 2'b00, 1'b1, 1'b0);
    step("drain2_a", 2'b01, 2'b10, 2'b00, 1'b1, 1'b0);
    step("drain2_b", 2'b01, 2'b10, 2'b00, 1'b1, 1'b0);
    drv(2'b11, 2'b00, 1'b0);
    step("wait_last", 2'b00, 2'b10, 2'b00, 1'b1, 1'b0);

    // Ack arriving as the owner drops cyc is still forwarded
    drv(2'b10, 2'b00, 1'b1);
    step("ack_on_release", 2'b01, 2'b10, 2'b00, 1'b0, 1'b0);

    // Master 1 reads three words while master 0 also requests
    drv(2'b10, 2'b00, 1'b0);
    step("idle_m1", 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
    drv(2'b11, 2'b10, 1'b0);
    for (int i = 0; i < 3; i++)
      step_bus("m1_read", 2'b00, 2'b01, 2'b00, 1'b1, 1'b1, ADDR1, 32'h0);
    drv(2'b11, 2'b00, 1'b1);
    bus.i_s_data = 32'hDEADBEEF;
    step_bus("m1_ack_data", 2'b10, 2'b01, 2'b00, 1'b1, 1'b0, ADDR1, 32'hDEADBEEF);
    step("m1_ack_b", 2'b10, 2'b01, 2'b00, 1'b1, 1'b0);
    step("m1_ack_c", 2'b10, 2'b01, 2'b00, 1'b1, 1'b0);

    // Watchdog: one request, no response
    drv(2'b11, 2'b10, 1'b0);
    step("to_accept", 2'b00, 2'b01, 2'b00, 1'b1, 1'b1);
    drv(2'b11, 2'b00, 1'b0);
    for (int i = 0; i < 8; i++)
      step("to_wait", 2'b00, 2'b01, 2'b00, 1'b1, 1'b0);
    step("to_fire", 2'b00, 2'b11, 2'b10, 1'b0, 1'b0);

    // Count cleared by the watchdog: four accepts fit again
    drv(2'b11, 2'b10, 1'b0);
    for (int i = 0; i < 4; i++)
      step("post_to_accept", 2'b00, 2'b01, 2'b00, 1'b1, 1'b1);
    step("post_to_full", 2'b00, 2'b11, 2'b00, 1'b1, 1'b0);

    // Reset mid-transaction in OWN1: outputs drop with no clock edge
    resetn = 1'b0;
    drv(2'b11, 2'b10, 1'b1);
    step("rst_mid", 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
    resetn = 1'b1;
    drv(2'b01, 2'b00, 1'b0);
    step("rst_release_idle", 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
    drv(2'b01, 2'b01, 1'b0);
    step("resume_accept", 2'b00, 2'b10, 2'b00, 1'b1, 1'b1);

    drv(2'b00, 2'b00, 1'b0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain_queue: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
